// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver.
//   rx_state_t  : receiver FSM encoding
//   OS_RATE_DEF : default baud_clk edges per bit
//   MID_SAMPLE  : oversample index used to confirm the start bit
//   BAUD_*      : rate select codes shared with the baud generators
package uart_rx_os16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_WAIT   = 3'd5
  } rx_state_t;

  localparam int         OS_RATE_DEF = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;

  localparam logic [1:0] BAUD_9600   = 2'd0;
  localparam logic [1:0] BAUD_19200  = 2'd1;
  localparam logic [1:0] BAUD_57600  = 2'd2;
  localparam logic [1:0] BAUD_115200 = 2'd3;

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-result bundle from the UART receiver to its consumer.
//   rx_data    : last received word
//   rx_valid   : one-clock strobe, rx_data and flags updated
//   frame_err  : stop bit was 0 (only meaningful with rx_valid)
//   parity_err : parity mismatch (only meaningful with rx_valid)
//   busy       : receiver is inside a frame
// master = receiver side, slave = consumer side.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output rx_data, rx_valid, frame_err, parity_err, busy);
  modport slave  (input  rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_os16_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input.
//   clock, reset_n : system clock, async active-low reset
//   d              : asynchronous input
//   q              : d after STAGES flops; all flops reset to RESET_VAL
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ff <= {STAGES{RESET_VAL}};
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// UART receive engine driven by a 16x oversample square wave (baud_clk).
// baud_clk is edge-detected as data; all logic runs on clock.
//   clock, reset_n        : system clock, async active-low reset
//   baud_clk              : oversample square wave from the baud generator
//   rx                    : asynchronous serial line, idle high
//   parity_en, parity_odd : parity configuration, latched per frame
//   rx_bus (master)       : rx_data / rx_valid / frame_err / parity_err / busy
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low sample
// ST_START  | confirming start bit at its midpoint
// ST_DATA   | sampling data bits, LSB first
// ST_PARITY | sampling parity bit
// ST_STOP   | sampling stop bit, result published next clock
// ST_WAIT   | stop bit was low, wait for line to return high
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OS_RATE     = OS_RATE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             baud_clk,
  input  logic             rx,
  input  logic             parity_en,
  input  logic             parity_odd,
  uart_rx_os16_if.master   rx_bus
);

  localparam int             BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [3:0]     OS_LAST  = 4'(OS_RATE - 1);

  rx_state_t            state, state_nxt;
  logic                 rx_s;
  logic                 baud_q;
  logic                 tick;
  logic [3:0]           os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_q, par_odd_q, par_err_q;
  logic                 os_clr, do_start, do_shift, do_par, do_stop;
  logic                 counting;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign tick     = ~baud_q & baud_clk;
  assign counting = (state != ST_IDLE) && (state != ST_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    do_start  = 1'b0;
    do_shift  = 1'b0;
    do_par    = 1'b0;
    do_stop   = 1'b0;
    case (state)
      ST_IDLE: if (tick && !rx_s) begin
        state_nxt = ST_START;
        os_clr    = 1'b1;
      end
      ST_START: if (tick && os_cnt == MID_SAMPLE) begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DATA;
          os_clr    = 1'b1;
          do_start  = 1'b1;
        end
      end
      ST_DATA: if (tick && os_cnt == OS_LAST) begin
        do_shift = 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (tick && os_cnt == OS_LAST) begin
        do_par    = 1'b1;
        state_nxt = ST_STOP;
      end
      // Leaving mid stop bit lets a start edge right after one stop bit be caught.
      ST_STOP: if (tick && os_cnt == OS_LAST) begin
        do_stop   = 1'b1;
        state_nxt = rx_s ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: if (tick && rx_s) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_q            <= 1'b0;
      os_cnt            <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      par_en_q          <= 1'b0;
      par_odd_q         <= 1'b0;
      par_err_q         <= 1'b0;
      rx_bus.rx_data    <= '0;
      rx_bus.rx_valid   <= 1'b0;
      rx_bus.frame_err  <= 1'b0;
      rx_bus.parity_err <= 1'b0;
    end else begin
      baud_q <= baud_clk;

      if (os_clr)                os_cnt <= '0;
      else if (tick && counting) os_cnt <= os_cnt + 4'd1;

      if (do_start) begin
        bit_cnt   <= '0;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        par_err_q <= 1'b0;
      end else if (do_shift) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      // Line is LSB first, so entering at the MSB leaves the word aligned.
      if (do_shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

      if (do_par) par_err_q <= ((^shreg) ^ rx_s) != par_odd_q;

      if (do_stop) rx_bus.rx_data <= shreg;
      rx_bus.rx_valid   <= do_stop;
      rx_bus.frame_err  <= do_stop & ~rx_s;
      rx_bus.parity_err <= do_stop & par_en_q & par_err_q;
    end
  end

  assign rx_bus.busy = (state != ST_IDLE);

endmodule
